// File: rtl/reg_scoreboard.sv
// Purpose: GPR scoreboard for ID; tracks in-flight writes and stalls issue on RAW/WAW hazards.
// Latency: stall/hazard_mask/pending are combinational; a newly loaded counter is visible next cycle.
// Backpressure: hold freezes all counters and suppresses stall/issue; a stalled instruction loads nothing.
module reg_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter int MAX_LATENCY    = 3,
  localparam int LAT_WIDTH     = $clog2(MAX_LATENCY + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     hold,
  input  logic                                     issue_valid,
  input  logic [NUM_READ_PORTS-1:0]                read_en,
  input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] read_addr,
  input  logic                                     write_en,
  input  logic [REG_ADDR_WIDTH-1:0]                write_addr,
  input  logic [LAT_WIDTH-1:0]                     write_latency,
  output logic                                     stall,
  output logic [NUM_READ_PORTS-1:0]                hazard_mask,
  output logic                                     pending
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [LAT_WIDTH-1:0] MAX_LAT = LAT_WIDTH'(MAX_LATENCY);

  // Register 0 is hardwired zero, so it carries no counter.
  logic [LAT_WIDTH-1:0] cnt      [1:NUM_REGS-1];
  logic [LAT_WIDTH-1:0] cnt_view [0:NUM_REGS-1];
  logic [LAT_WIDTH-1:0] lat_c;
  logic                 waw;
  logic                 accept;

  // Flat view of the counters with a constant zero slot for register 0, plus the busy summary.
  always_comb begin
    cnt_view[0] = '0;
    pending     = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_view[r] = cnt[r];
      pending     = pending | (cnt[r] != '0);
    end
  end

  // Hazard detection: one indexed lookup per read port, plus the WAW check on the destination.
  always_comb begin
    lat_c = (write_latency > MAX_LAT) ? MAX_LAT : write_latency;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      hazard_mask[i] = read_en[i]
                    && (read_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0)
                    && (cnt_view[read_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] != '0);
    end
    waw    = write_en && (write_addr != '0) && (cnt_view[write_addr] > lat_c);
    stall  = issue_valid && !hold && ((|hazard_mask) || waw);
    accept = issue_valid && !hold && !stall;
  end

  // Counter update: reset clears, hold freezes, otherwise count down and load on an accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < NUM_REGS; r++) cnt[r] <= '0;
    end else if (!hold) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (accept && write_en && (write_addr == REG_ADDR_WIDTH'(r))) begin
          cnt[r] <= lat_c;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Purpose: directed self-checking bench for reg_scoreboard.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: exercises hold freezing, stall suppression of counter loads and reset mid-flight.
module tb_reg_scoreboard;

  logic       clk;
  logic       rst;
  logic       hold;
  logic       issue_valid;
  logic [1:0] read_en;
  logic [9:0] read_addr;
  logic       write_en;
  logic [4:0] write_addr;
  logic [1:0] write_latency;
  logic       stall;
  logic [1:0] hazard_mask;
  logic       pending;

  int checks = 0;
  int errors = 0;

  reg_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .issue_valid  (issue_valid),
    .read_en      (read_en),
    .read_addr    (read_addr),
    .write_en     (write_en),
    .write_addr   (write_addr),
    .write_latency(write_latency),
    .stall        (stall),
    .hazard_mask  (hazard_mask),
    .pending      (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle's worth of inputs, then let the combinational outputs settle.
  task automatic drive(input logic iv, input logic hd, input logic [1:0] ren,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic we, input logic [4:0] wa, input logic [1:0] wl);
    issue_valid   = iv;
    hold          = hd;
    read_en       = ren;
    read_addr     = {a1, a0};
    write_en      = we;
    write_addr    = wa;
    write_latency = wl;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 2'd0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (hazard_mask !== 2'b00) begin errors++; $display("FAIL reset_mask: got %b want 00", hazard_mask); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd8, 2'd1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_issue_stall: got %b want 0", stall); end
    tick();
    drive(1'b1, 1'b0, 2'b01, 5'd8, 5'd0, 1'b0, 5'd0, 2'd0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_c1_stall: got %b want 1", stall); end
    checks++; if (hazard_mask !== 2'b01) begin errors++; $display("FAIL lu_c1_mask: got %b want 01", hazard_mask); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL lu_c1_pending: got %b want 1", pending); end
    tick();
    drive(1'b1, 1'b0, 2'b01, 5'd8, 5'd0, 1'b0, 5'd0, 2'd0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_c2_stall: got %b want 0", stall); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL lu_c2_pending: got %b want 0", pending); end
    tick();
  endtask

  task automatic test_hold();
    logic [3:0] exp_stall;
    exp_stall = 4'b0111;  // cycle k of the non-hold window: cnt 3,2,1,0
    drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 2'd3);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_issue_stall: got %b want 0", stall); end
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 2'b01, 5'd4, 5'd0, 1'b0, 5'd0, 2'd0);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_frozen_stall[%0d]: got %b want 0", k, stall); end
      checks++; if (hazard_mask !== 2'b01) begin errors++; $display("FAIL hold_frozen_mask[%0d]: got %b want 01", k, hazard_mask); end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 2'b01, 5'd4, 5'd0, 1'b0, 5'd0, 2'd0);
      checks++; if (stall !== exp_stall[k]) begin errors++; $display("FAIL hold_release_stall[%0d]: got %b want %b", k, stall, exp_stall[k]); end
      tick();
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 2'd3);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_write_stall: got %b want 0", stall); end
    tick();
    drive(1'b1, 1'b0, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL zero_pending: got %b want 0", pending); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_read_stall: got %b want 0", stall); end
    checks++; if (hazard_mask !== 2'b00) begin errors++; $display("FAIL zero_read_mask: got %b want 00", hazard_mask); end
    tick();
  endtask

  task automatic test_waw();
    // cnt[9]: 3 after the first write; retry of latency-1 write stalls while cnt>1.
    drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 2'd3);
    tick();
    drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 2'd1);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_c1_stall: got %b want 1 (cnt 3)", stall); end
    checks++; if (hazard_mask !== 2'b00) begin errors++; $display("FAIL waw_c1_mask: got %b want 00", hazard_mask); end
    tick();
    drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 2'd1);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_c2_stall: got %b want 1 (cnt 2)", stall); end
    tick();
    drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 2'd1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_c3_stall: got %b want 0 (cnt 1 == lat)", stall); end
    tick();
    drive(1'b1, 1'b0, 2'b10, 5'd0, 5'd9, 1'b0, 5'd0, 2'd0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_c4_stall: got %b want 1 (reloaded cnt 1)", stall); end
    checks++; if (hazard_mask !== 2'b10) begin errors++; $display("FAIL waw_c4_mask: got %b want 10", hazard_mask); end
    tick();
    drive(1'b1, 1'b0, 2'b10, 5'd0, 5'd9, 1'b0, 5'd0, 2'd0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_c5_stall: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_no_load_on_stall();
    drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 2'd2);
    tick();
    // cnt[7]=2: read $7 stalls, so the write to $10 must not load.
    drive(1'b1, 1'b0, 2'b01, 5'd7, 5'd0, 1'b1, 5'd10, 2'd3);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nls_stall: got %b want 1", stall); end
    checks++; if (hazard_mask !== 2'b01) begin errors++; $display("FAIL nls_mask: got %b want 01", hazard_mask); end
    tick();
    // cnt[7]=1, cnt[10]=0; mask is reported without issue_valid; reset asserted this cycle.
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b11, 5'd7, 5'd10, 1'b0, 5'd0, 2'd0);
    checks++; if (hazard_mask !== 2'b01) begin errors++; $display("FAIL nls_after_mask: got %b want 01", hazard_mask); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nls_noissue_stall: got %b want 0", stall); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL nls_pre_rst_pending: got %b want 1", pending); end
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b11, 5'd7, 5'd10, 1'b0, 5'd0, 2'd0);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL nls_rst_pending: got %b want 0", pending); end
    checks++; if (hazard_mask !== 2'b00) begin errors++; $display("FAIL nls_rst_mask: got %b want 00", hazard_mask); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nls_rst_stall: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_self_dep();
    // Source equal to destination is checked against the pre-issue counter.
    drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd12, 2'd1);
    tick();
    drive(1'b1, 1'b0, 2'b01, 5'd12, 5'd0, 1'b1, 5'd12, 2'd3);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL self_c1_stall: got %b want 1", stall); end
    tick();
    drive(1'b1, 1'b0, 2'b01, 5'd12, 5'd0, 1'b1, 5'd12, 2'd3);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL self_c2_stall: got %b want 0", stall); end
    tick();
    drive(1'b0, 1'b0, 2'b01, 5'd12, 5'd0, 1'b0, 5'd0, 2'd0);
    checks++; if (hazard_mask !== 2'b01) begin errors++; $display("FAIL self_c3_mask: got %b want 01", hazard_mask); end
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    hold          = 1'b0;
    issue_valid   = 1'b0;
    read_en       = '0;
    read_addr     = '0;
    write_en      = 1'b0;
    write_addr    = '0;
    write_latency = '0;
    test_reset();
    test_load_use();
    test_hold();
    test_zero_reg();
    test_waw();
    test_no_load_on_stall();
    test_self_dep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
